// File: rtl/frame_draw_scheduler_pkg.sv
// Shared definitions for the per-frame draw scheduler: FSM state
// encoding, drawing-client index map and default screen geometry.
package frame_draw_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RUN     = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    localparam int CL_ERASE = 0;
    localparam int CL_ROAD  = 1;
    localparam int CL_OBST  = 2;
    localparam int CL_CAR   = 3;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;

endpackage

// File: rtl/next_client_sel.sv
// Combinational next-client picker: returns the lowest set bit of mask
// strictly above cur_idx (or the lowest set bit at all when from_start).
// Ports: mask, cur_idx, from_start in; next_idx, valid out.
module next_client_sel
    import frame_draw_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic             from_start,
    output logic [IDX_W-1:0] next_idx,
    output logic             valid
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx = '0;
        valid    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || i > int'(cur_idx))) begin
                next_idx = IDX_W'(i);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer/arbiter for the single VGA pixel-write port.
// Ports: clock/resetn; frame_tick, run_enable, client_en control;
// cl_start/cl_done/cl_plot/cl_x/cl_y/cl_colour client side;
// vga_* registered adapter writes; frame_busy, active_idx,
// overrun_cnt, timeout_flag status.
module frame_draw_scheduler
    import frame_draw_scheduler_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int X_W            = DEF_X_W,
    parameter int Y_W            = DEF_Y_W,
    parameter int COLOUR_W       = DEF_COLOUR_W,
    parameter int TIMEOUT_CYCLES = 20000,
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            frame_tick,
    input  logic                            run_enable,
    input  logic [NUM_CLIENTS-1:0]          client_en,
    output logic [NUM_CLIENTS-1:0]          cl_start,
    input  logic [NUM_CLIENTS-1:0]          cl_done,
    input  logic [NUM_CLIENTS-1:0]          cl_plot,
    input  logic [NUM_CLIENTS*X_W-1:0]      cl_x,
    input  logic [NUM_CLIENTS*Y_W-1:0]      cl_y,
    input  logic [NUM_CLIENTS*COLOUR_W-1:0] cl_colour,
    output logic                            vga_plot,
    output logic [X_W-1:0]                  vga_x,
    output logic [Y_W-1:0]                  vga_y,
    output logic [COLOUR_W-1:0]             vga_colour,
    output logic                            frame_busy,
    output logic [IDX_W-1:0]                active_idx,
    output logic [7:0]                      overrun_cnt,
    output logic                            timeout_flag
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                 state;
    state_t                 state_n;
    logic [NUM_CLIENTS-1:0] mask_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WD_W-1:0]        wdog;

    logic                   sel_first;
    logic [NUM_CLIENTS-1:0] sel_mask;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic                   act_done;
    logic                   wd_expire;
    logic                   start_frame;

    // One selector serves both the frame start (fresh client_en, search
    // from the bottom) and the advance step (latched mask, above idx).
    assign sel_first = (state == IDLE);
    assign sel_mask  = sel_first ? client_en : mask_q;

    next_client_sel #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_sel (
        .mask       (sel_mask),
        .cur_idx    (idx_q),
        .from_start (sel_first),
        .next_idx   (sel_idx),
        .valid      (sel_valid)
    );

    assign act_done    = cl_done[idx_q];
    assign wd_expire   = (state == RUN) &&
                         (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign start_frame = (state == IDLE) && frame_tick &&
                         run_enable && sel_valid;

    always_comb begin
        state_n    = state;
        cl_start   = '0;
        frame_busy = (state != IDLE);
        active_idx = (state == IDLE) ? '0 : idx_q;
        unique case (state)
            IDLE:    if (start_frame) state_n = LAUNCH;
            LAUNCH: begin
                cl_start[idx_q] = 1'b1;
                state_n         = RUN;
            end
            RUN:     if (act_done || wd_expire) state_n = ADVANCE;
            ADVANCE: state_n = sel_valid ? LAUNCH : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            wdog         <= '0;
            timeout_flag <= 1'b0;
            overrun_cnt  <= 8'd0;
            vga_plot     <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_colour   <= '0;
        end else begin
            state <= state_n;
            if (start_frame) begin
                mask_q <= client_en;
                idx_q  <= sel_idx;
            end
            if (state == ADVANCE && sel_valid) idx_q <= sel_idx;

            if (state == LAUNCH)   wdog <= '0;
            else if (state == RUN) wdog <= wdog + 1'b1;

            // A genuine done on the last watchdog cycle is not an abort.
            if (wd_expire && !act_done) timeout_flag <= 1'b1;

            // Any tick outside IDLE is dropped, including the final
            // ADVANCE cycle: ticks are never queued.
            if (frame_tick && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;

            if (state == RUN) begin
                vga_plot   <= cl_plot[idx_q];
                vga_x      <= cl_x[int'(idx_q)*X_W +: X_W];
                vga_y      <= cl_y[int'(idx_q)*Y_W +: Y_W];
                vga_colour <= cl_colour[int'(idx_q)*COLOUR_W +: COLOUR_W];
            end else begin
                vga_plot <= 1'b0;
            end
        end
    end

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Per-frame sequencer and arbiter for the single VGA adapter pixel-write port.
- On each frame tick it launches the drawing clients in fixed index order, e.g. 0 erase, 1 road, 2 obstacles, 3 player car.
- It forwards only the active client's pixel writes to the adapter.
- It reports frame overruns and hung clients to the top level.

Parameters:
- NUM_CLIENTS, 4, number of drawing clients; client 0 is launched first.
- X_W, 8, pixel x width (160-column mode).
- Y_W, 7, pixel y width (120-row mode).
- COLOUR_W, 3, pixel colour width.
- TIMEOUT_CYCLES, 20000, maximum cycles a client may stay busy before it is aborted.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per display frame.
- run_enable  in  1  gate for new frames (driveEnable); a frame already in progress always completes.
- client_en  in  NUM_CLIENTS  per-client enable, sampled at frame start.
- cl_start  out  NUM_CLIENTS  one-cycle launch pulse, one-hot.
- cl_done  in  NUM_CLIENTS  one-cycle completion pulse from each client.
- cl_plot  in  NUM_CLIENTS  per-client pixel write strobe.
- cl_x  in  NUM_CLIENTS*X_W  packed x coordinates; client i uses bits [i*X_W +: X_W].
- cl_y  in  NUM_CLIENTS*Y_W  packed y coordinates, same packing.
- cl_colour  in  NUM_CLIENTS*COLOUR_W  packed colours, same packing.
- vga_plot  out  1  registered write strobe to the adapter.
- vga_x  out  X_W  registered x coordinate.
- vga_y  out  Y_W  registered y coordinate.
- vga_colour  out  COLOUR_W  registered colour.
- frame_busy  out  1  high from launch of the first client until the frame ends.
- active_idx  out  clog2(NUM_CLIENTS)  index of the current client; 0 when idle.
- overrun_cnt  out  8  saturating count of frame ticks dropped while busy.
- timeout_flag  out  1  sticky; set on any client abort.

Behaviour:
- Reset (synchronous, resetn=0 at a clock edge) drives every output to 0, including vga_*, cl_start, overrun_cnt and timeout_flag.
  - Reset mid-frame abandons the frame immediately. No done pulse is awaited.
- States: IDLE, LAUNCH, RUN, ADVANCE.
- IDLE:
  - frame_tick & run_enable: latch mask=client_en, set idx=lowest set bit of mask, go to LAUNCH.
  - If mask==0: stay in IDLE, frame_busy stays 0.
  - frame_tick with run_enable=0 is ignored and not counted.
- LAUNCH (1 cycle): cl_start[idx]=1, clear watchdog, go to RUN. frame_busy=1 from this cycle.
- RUN: wait for cl_done[idx].
  - cl_done from non-active clients is ignored.
  - Watchdog counts RUN cycles. At count==TIMEOUT_CYCLES-1 without done: set timeout_flag and treat as done.
- ADVANCE (1 cycle): idx = next set bit of mask above idx.
  - If one exists: go to LAUNCH.
  - Else: go to IDLE. frame_busy drops on the cycle IDLE is entered.
- Launch order is strictly ascending index. No client is launched twice per frame. A gap of 2 cycles (ADVANCE+LAUNCH) separates clients.
- Write mux:
  - When state==RUN, the registered outputs take the values of client idx: vga_plot<=cl_plot[idx], vga_x/y/colour<=client idx fields.
  - Latency is exactly 1 cycle.
  - Outside RUN, vga_plot<=0 and coordinates hold their previous value.
  - Plot from a non-active client is dropped.
- Done and plot in the same cycle: the plot is forwarded; done is honoured.
- frame_tick while frame_busy (or in LAUNCH/ADVANCE): tick is dropped and overrun_cnt increments, saturating at 255. The current frame is unaffected.
- frame_tick in the same cycle as the frame's final ADVANCE→IDLE: counts as an overrun (not queued).
- run_enable falling mid-frame: no effect until IDLE.
- client_en changes mid-frame: ignored until the next frame start.
- timeout_flag and overrun_cnt clear only on reset.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, LAUNCH, RUN, ADVANCE);
  - client index constants CL_ERASE=0, CL_ROAD=1, CL_OBST=2, CL_CAR=3;
  - default screen widths X_W/Y_W/COLOUR_W.
- One natural sub-module: next_client_sel. It is combinational: given mask and current idx, it returns the next set index and a valid flag. It is reused for both the first-client and advance selections.

Test Plan:
1. Reset, then frame_tick with run_enable=1, client_en=4'b1111, each client returning done 10 cycles after its start:
   - cl_start pulses in order 0,1,2,3;
   - frame_busy stays high throughout;
   - after client 3 done + 1 cycle, state is IDLE and frame_busy=0.
2. client_en=4'b1010:
   - only cl_start[1] then cl_start[3];
   - frame_tick with client_en=0 → no start pulses and frame_busy stays 0.
3. Client 1 drives plot with x=8'd37, y=7'd100, colour=3'b101 while active, and client 2 drives plot at the same time:
   - the next cycle shows vga_plot=1 with client 1's values only;
   - client 2's plot never appears.
4. Client 2 never asserts done, with TIMEOUT_CYCLES=50:
   - cl_start[2] is followed 50 cycles later by timeout_flag=1;
   - cl_start[3] fires 2 cycles after that.
5. Three frame_ticks during a busy frame → overrun_cnt=3. 300 overruns → overrun_cnt holds at 255.
6. Assert resetn=0 mid-RUN:
   - the next cycle shows all outputs at 0;
   - a late cl_done afterwards causes no launch;
   - a fresh frame_tick restarts from client 0.
